// File: rtl/wb_arbiter.sv
// Register-file write-port arbiter: merges pipeline writeback with a buffered
// secondary result stream, with starvation stall and per-register busy mask.
module wb_arbiter #(
   parameter int unsigned DEPTH    = 2,
   parameter int unsigned MAX_WAIT = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        pipe_we,
   input  logic [4:0]  pipe_wa,
   input  logic [31:0] pipe_wd,
   input  logic        sec_valid,
   output logic        sec_ready,
   input  logic [4:0]  sec_wa,
   input  logic [31:0] sec_wd,
   output logic        rf_we,
   output logic [4:0]  rf_wa,
   output logic [31:0] rf_wd,
   output logic        stall_req,
   output logic [31:0] busy_mask
);

   localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CW = PW + 1;
   localparam int unsigned WW = $clog2(MAX_WAIT + 1);

   logic [4:0]    mem_wa [DEPTH];
   logic [31:0]   mem_wd [DEPTH];
   logic [PW-1:0] rd_ptr, wr_ptr;
   logic [CW-1:0] count, count_nxt;
   logic [WW-1:0] wait_cnt, wait_nxt;

   logic          empty, sec_acc;
   logic          grant_head, grant_byp, enq;
   logic          sel_we;
   logic [4:0]    sel_wa;
   logic [31:0]   sel_wd;
   logic          stall_nxt;
   logic [PW-1:0] off;

   // Grant selection, FIFO bookkeeping and starvation tracking
   always_comb begin
      empty      = (count == '0);
      sec_ready  = (count < CW'(DEPTH));
      sec_acc    = sec_valid & sec_ready;
      grant_head = !empty && (stall_req || !pipe_we);
      grant_byp  = !stall_req && !pipe_we && empty && sec_acc;
      enq        = sec_acc && !grant_byp;

      sel_we = 1'b0;
      sel_wa = '0;
      sel_wd = '0;
      if (grant_head) begin
         sel_we = 1'b1;
         sel_wa = mem_wa[rd_ptr];
         sel_wd = mem_wd[rd_ptr];
      end else if (!stall_req && pipe_we) begin
         sel_we = 1'b1;
         sel_wa = pipe_wa;
         sel_wd = pipe_wd;
      end else if (grant_byp) begin
         sel_we = 1'b1;
         sel_wa = sec_wa;
         sel_wd = sec_wd;
      end

      count_nxt = count + CW'(enq) - CW'(grant_head);

      if (empty || grant_head)
         wait_nxt = '0;
      else if (wait_cnt != WW'(MAX_WAIT))
         wait_nxt = wait_cnt + WW'(1);
      else
         wait_nxt = wait_cnt;
      stall_nxt = (wait_nxt == WW'(MAX_WAIT));
   end

   // Busy mask over live FIFO entries; x0 never marks busy
   always_comb begin
      busy_mask = '0;
      off       = '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
         off = PW'(PW'(i) - rd_ptr);
         if (({1'b0, off} < count) && (mem_wa[i] != 5'd0))
            busy_mask[mem_wa[i]] = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (enq) begin
         mem_wa[wr_ptr] <= sec_wa;
         mem_wd[wr_ptr] <= sec_wd;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rd_ptr    <= '0;
         wr_ptr    <= '0;
         count     <= '0;
         wait_cnt  <= '0;
         stall_req <= 1'b0;
         rf_we     <= 1'b0;
         rf_wa     <= '0;
         rf_wd     <= '0;
      end else begin
         if (enq)
            wr_ptr <= wr_ptr + PW'(1);
         if (grant_head)
            rd_ptr <= rd_ptr + PW'(1);
         count     <= count_nxt;
         wait_cnt  <= wait_nxt;
         stall_req <= stall_nxt;
         // A granted x0 write consumes its slot but never strobes the file
         rf_we     <= sel_we && (sel_wa != 5'd0);
         if (sel_we) begin
            rf_wa <= sel_wa;
            rf_wd <= sel_wd;
         end
      end
   end

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed self-checking bench for wb_arbiter (DEPTH=2, MAX_WAIT=4).
module tb_wb_arbiter;

   logic        clk;
   logic        rst;
   logic        pipe_we;
   logic [4:0]  pipe_wa;
   logic [31:0] pipe_wd;
   logic        sec_valid;
   logic        sec_ready;
   logic [4:0]  sec_wa;
   logic [31:0] sec_wd;
   logic        rf_we;
   logic [4:0]  rf_wa;
   logic [31:0] rf_wd;
   logic        stall_req;
   logic [31:0] busy_mask;

   int n_tests = 0;
   int n_fail  = 0;

   wb_arbiter #(.DEPTH(2), .MAX_WAIT(4)) dut (
      .clk       (clk),
      .rst       (rst),
      .pipe_we   (pipe_we),
      .pipe_wa   (pipe_wa),
      .pipe_wd   (pipe_wd),
      .sec_valid (sec_valid),
      .sec_ready (sec_ready),
      .sec_wa    (sec_wa),
      .sec_wd    (sec_wd),
      .rf_we     (rf_we),
      .rf_wa     (rf_wa),
      .rf_wd     (rf_wd),
      .stall_req (stall_req),
      .busy_mask (busy_mask)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst       = 1'b0;
      pipe_we   = 1'b0;
      pipe_wa   = '0;
      pipe_wd   = '0;
      sec_valid = 1'b0;
      sec_wa    = '0;
      sec_wd    = '0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      tick();

      // 1. Reset and idle
      check("rst_rf_we",     32'(rf_we),     32'd0);
      check("rst_stall",     32'(stall_req), 32'd0);
      check("rst_sec_ready", 32'(sec_ready), 32'd1);
      check("rst_busy",      busy_mask,      32'd0);
      tick();
      check("idle_rf_we",    32'(rf_we),     32'd0);

      // 1b. Reset mid-stream with two entries queued
      pipe_we = 1'b1; pipe_wa = 5'd20; pipe_wd = 32'h0000_0001;
      sec_valid = 1'b1; sec_wa = 5'd1; sec_wd = 32'h0000_00A1;
      tick();
      sec_wa = 5'd2; sec_wd = 32'h0000_00A2;
      tick();
      sec_valid = 1'b0;
      check("mid_busy_pre",  busy_mask,      32'h0000_0006);
      check("mid_ready_pre", 32'(sec_ready), 32'd0);
      #2 rst = 1'b0;
      #1;
      check("mid_busy_rst",  busy_mask,      32'd0);
      check("mid_ready_rst", 32'(sec_ready), 32'd1);
      check("mid_rf_we_rst", 32'(rf_we),     32'd0);
      pipe_we = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      for (int k = 0; k < 3; k++) begin
         tick();
         check("post_rst_rf_we", 32'(rf_we), 32'd0);
      end
      check("post_rst_busy", busy_mask, 32'd0);

      // 2. Primary only
      pipe_we = 1'b1; pipe_wa = 5'd5; pipe_wd = 32'hDEAD_BEEF;
      tick();
      check("pri_we", 32'(rf_we), 32'd1);
      check("pri_wa", 32'(rf_wa), 32'd5);
      check("pri_wd", rf_wd,      32'hDEAD_BEEF);
      pipe_wa = 5'd0; pipe_wd = 32'h1234_5678;
      tick();
      check("pri_x0_we", 32'(rf_we), 32'd0);
      pipe_we = 1'b0;
      tick();
      check("pri_idle_we", 32'(rf_we), 32'd0);

      // 3. Bypass
      check("byp_ready_pre", 32'(sec_ready), 32'd1);
      sec_valid = 1'b1; sec_wa = 5'd7; sec_wd = 32'h0000_0012;
      tick();
      sec_valid = 1'b0;
      check("byp_we",    32'(rf_we),     32'd1);
      check("byp_wa",    32'(rf_wa),     32'd7);
      check("byp_wd",    rf_wd,          32'h0000_0012);
      check("byp_busy",  busy_mask,      32'd0);
      check("byp_ready", 32'(sec_ready), 32'd1);
      tick();
      check("byp_once", 32'(rf_we), 32'd0);

      // 4. Fill under continuous primary traffic, starvation stall
      pipe_we = 1'b1; pipe_wa = 5'd20; pipe_wd = 32'hCAFE_0000;
      sec_valid = 1'b1; sec_wa = 5'd3; sec_wd = 32'h0000_0033;
      tick();
      check("fill_ready1", 32'(sec_ready), 32'd1);
      sec_wa = 5'd4; sec_wd = 32'h0000_0044;
      tick();
      sec_valid = 1'b0;
      check("fill_ready0", 32'(sec_ready), 32'd0);
      check("fill_busy",   busy_mask,      32'h0000_0018);
      check("fill_pri_wa", 32'(rf_wa),     32'd20);
      tick();
      check("starve_c3", 32'(stall_req), 32'd0);
      tick();
      check("starve_c4", 32'(stall_req), 32'd0);
      tick();
      check("starve_c5", 32'(stall_req), 32'd1);
      tick();
      check("head3_we",    32'(rf_we),     32'd1);
      check("head3_wa",    32'(rf_wa),     32'd3);
      check("head3_wd",    rf_wd,          32'h0000_0033);
      check("head3_stall", 32'(stall_req), 32'd0);
      check("head3_busy",  busy_mask,      32'h0000_0010);
      for (int k = 0; k < 3; k++) begin
         tick();
         check("starve2_low", 32'(stall_req), 32'd0);
      end
      tick();
      check("starve2_high", 32'(stall_req), 32'd1);
      tick();
      check("head4_we",    32'(rf_we),     32'd1);
      check("head4_wa",    32'(rf_wa),     32'd4);
      check("head4_wd",    rf_wd,          32'h0000_0044);
      check("head4_stall", 32'(stall_req), 32'd0);
      check("head4_busy",  busy_mask,      32'd0);
      pipe_we = 1'b0;
      tick();

      // 5. Full FIFO with simultaneous dequeue and enqueue
      pipe_we = 1'b1; pipe_wa = 5'd21; pipe_wd = 32'h0000_0021;
      sec_valid = 1'b1; sec_wa = 5'd10; sec_wd = 32'h0000_0100;
      tick();
      sec_wa = 5'd11; sec_wd = 32'h0000_0101;
      tick();
      check("full_ready0", 32'(sec_ready), 32'd0);
      check("full_busy",   busy_mask,      32'h0000_0C00);
      pipe_we = 1'b0;
      sec_wa = 5'd12; sec_wd = 32'h0000_0102;
      tick();
      check("ord10_wa", 32'(rf_wa), 32'd10);
      check("ord10_wd", rf_wd,      32'h0000_0100);
      check("ord_ready_c3", 32'(sec_ready), 32'd1);
      tick();
      check("ord11_wa", 32'(rf_wa), 32'd11);
      check("ord11_wd", rf_wd,      32'h0000_0101);
      check("ord_busy_c4", busy_mask, 32'h0000_1000);
      sec_wa = 5'd13; sec_wd = 32'h0000_0103;
      tick();
      sec_valid = 1'b0;
      check("ord12_wa", 32'(rf_wa), 32'd12);
      check("ord12_wd", rf_wd,      32'h0000_0102);
      check("ord_busy_c5", busy_mask, 32'h0000_2000);
      tick();
      check("ord13_we", 32'(rf_we), 32'd1);
      check("ord13_wa", 32'(rf_wa), 32'd13);
      check("ord13_wd", rf_wd,      32'h0000_0103);
      check("ord_busy_end", busy_mask, 32'd0);
      tick();
      check("ord_no_dup", 32'(rf_we), 32'd0);

      // 6. Two queued writes to the same register
      pipe_we = 1'b1; pipe_wa = 5'd22; pipe_wd = 32'h0000_0022;
      sec_valid = 1'b1; sec_wa = 5'd9; sec_wd = 32'h0000_00B1;
      tick();
      sec_wd = 32'h0000_00B2;
      tick();
      sec_valid = 1'b0;
      pipe_we = 1'b0;
      check("same_busy_2", busy_mask, 32'h0000_0200);
      tick();
      check("same_first_wd", rf_wd,     32'h0000_00B1);
      check("same_busy_1",   busy_mask, 32'h0000_0200);
      tick();
      check("same_last_wa", 32'(rf_wa), 32'd9);
      check("same_last_wd", rf_wd,      32'h0000_00B2);
      check("same_busy_0",  busy_mask,  32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
